// File: rtl/uart_rx_byte_plnk.sv
// 8N1 UART receiver for the plank feedback link.
// Mid-bit sampling after a 2-flop synchroniser; byte or framing-error strobe.
module uart_rx_byte_plnk #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_rx_serial,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_rx_busy
);

  localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_HALF = CW'(HALF_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;

  state_t        w_state_nx;
  logic [CW-1:0] w_cnt_nx;
  logic [2:0]    w_bit_nx;
  logic [7:0]    w_shift_nx;
  logic [7:0]    w_data_nx;
  logic          w_valid_nx;
  logic          w_ferr_nx;
  logic          w_last;
  logic [CW-1:0] w_cnt_inc;

  assign w_last    = (r_cnt == C_LAST);
  assign w_cnt_inc = r_cnt + CW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx_serial;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_shift <= w_shift_nx;
      r_data  <= w_data_nx;
      r_valid <= w_valid_nx;
      r_ferr  <= w_ferr_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_data_nx  = r_data;
    w_valid_nx = 1'b0;
    w_ferr_nx  = 1'b0;
    if (!i_en) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
      w_bit_nx   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_cnt_nx = '0;
          if (!r_sync2) w_state_nx = S_START;
        end
        S_START: begin
          if (r_cnt == C_HALF) begin
            w_cnt_nx   = '0;
            w_state_nx = r_sync2 ? S_IDLE : S_DATA;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
        S_DATA: begin
          if (w_last) begin
            w_cnt_nx          = '0;
            w_shift_nx[r_bit] = r_sync2;
            w_bit_nx          = r_bit + 3'd1;
            if (r_bit == 3'd7) w_state_nx = S_STOP;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
        S_STOP: begin
          if (w_last) begin
            w_cnt_nx = '0;
            if (r_sync2) begin
              w_data_nx  = r_shift;
              w_valid_nx = 1'b1;
              w_state_nx = S_IDLE;
            end else begin
              w_ferr_nx  = 1'b1;
              w_state_nx = S_BRK;
            end
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end
        // a held-low line must return high before a new start is accepted
        S_BRK: begin
          w_cnt_nx = '0;
          if (r_sync2) w_state_nx = S_IDLE;
        end
        default: begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          w_bit_nx   = '0;
        end
      endcase
    end
  end

  assign o_rx_data   = r_data;
  assign o_rx_valid  = r_valid;
  assign o_frame_err = r_ferr;
  assign o_rx_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte_plnk.sv
// Scoreboard bench for uart_rx_byte_plnk at 16 clocks per bit.
// Stimulus pushes expected strobes; a negedge monitor pops and compares.
module tb_uart_rx_byte_plnk;

  localparam int CPB  = 16;
  localparam int TCLK = 10;
  localparam int TBIT = CPB * TCLK;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_en = 1'b1;
  logic       i_rx_serial = 1'b1;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_frame_err;
  logic       o_rx_busy;

  uart_rx_byte_plnk #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_rx_serial (i_rx_serial),
    .o_rx_data   (o_rx_data),
    .o_rx_valid  (o_rx_valid),
    .o_frame_err (o_frame_err),
    .o_rx_busy   (o_rx_busy)
  );

  always #(TCLK/2) i_clk = ~i_clk;

  typedef struct packed {
    logic       is_valid;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  logic [7:0] held = 8'h00;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         v_prev = -1;
  int         v_last = -1;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_v(input logic [7:0] d);
    q.push_back({1'b1, d});
    held = d;
  endtask

  task automatic push_e();
    q.push_back({1'b0, held});
  endtask

  task automatic align();
    @(posedge i_clk);
    #1;
  endtask

  // Caller aligns; the line is left at the stop-bit level.
  task automatic send_byte(input logic [7:0] d, input logic stop,
                           input int tbit, input bit chk_busy);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      i_rx_serial = fr[i];
      if (chk_busy && i == 0) begin
        #50;
        check("busy_in_start", int'(o_rx_busy), 1);
        #(tbit - 50);
      end else if (chk_busy && i == 9) begin
        #60;
        check("busy_in_stop", int'(o_rx_busy), 1);
        #(tbit - 60);
      end else begin
        #(tbit);
      end
    end
  endtask

  // Start bit and data bits 0..3, then half of bit 4.
  task automatic send_partial(input logic [7:0] d);
    i_rx_serial = 1'b0;
    #(TBIT);
    for (int i = 0; i < 4; i++) begin
      i_rx_serial = d[i];
      #(TBIT);
    end
    i_rx_serial = d[4];
    #(TBIT/2);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && (o_rx_valid || o_frame_err)) begin
        if (o_rx_valid && o_frame_err)
          check("strobes_exclusive", 1, 0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: valid=%0b err=%0b data=0x%0h, required none",
                   o_rx_valid, o_frame_err, o_rx_data);
        end else begin
          e = q.pop_front();
          check("strobe_kind", int'(o_rx_valid), int'(e.is_valid));
          check("rx_data", int'(o_rx_data), int'(e.data));
          if (o_rx_valid) begin
            v_prev = v_last;
            v_last = cyc;
          end
        end
      end
    end
  end

  initial begin
    #(400000);
    $display("FAIL watchdog: simulation time limit reached, required normal end");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_data", int'(o_rx_data), 0);
    check("rst_valid", int'(o_rx_valid), 0);
    check("rst_ferr", int'(o_frame_err), 0);
    check("rst_busy", int'(o_rx_busy), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (5) @(posedge i_clk);

    // single byte with busy tracking
    push_v(8'hAA);
    align();
    send_byte(8'hAA, 1'b1, TBIT, 1'b1);
    repeat (20) @(posedge i_clk);
    #1;
    check("busy_after_frame", int'(o_rx_busy), 0);

    // back-to-back, no idle gap
    push_v(8'h55);
    push_v(8'hA5);
    align();
    send_byte(8'h55, 1'b1, TBIT, 1'b0);
    send_byte(8'hA5, 1'b1, TBIT, 1'b0);
    repeat (20) @(posedge i_clk);
    check("b2b_spacing", v_last - v_prev, 160);

    // 4-cycle glitch is rejected
    align();
    i_rx_serial = 1'b0;
    #(4 * TCLK);
    i_rx_serial = 1'b1;
    #(2 * TCLK);
    check("glitch_busy", int'(o_rx_busy), 1);
    repeat (40) @(posedge i_clk);
    #1;
    check("glitch_idle", int'(o_rx_busy), 0);
    push_v(8'h3C);
    align();
    send_byte(8'h3C, 1'b1, TBIT, 1'b0);
    repeat (10) @(posedge i_clk);

    // framing error followed by a break
    push_e();
    align();
    send_byte(8'h0F, 1'b0, TBIT, 1'b0);
    #(50 * TCLK);
    check("break_busy", int'(o_rx_busy), 1);
    check("break_data_held", int'(o_rx_data), 'h3C);
    i_rx_serial = 1'b1;
    repeat (10) @(posedge i_clk);
    #1;
    check("break_released", int'(o_rx_busy), 0);
    push_v(8'hC3);
    align();
    send_byte(8'hC3, 1'b1, TBIT, 1'b0);
    repeat (10) @(posedge i_clk);

    // transmitter bit period about -4% and +4%
    push_v(8'h81);
    align();
    send_byte(8'h81, 1'b1, 154, 1'b0);
    repeat (10) @(posedge i_clk);
    push_v(8'h81);
    align();
    send_byte(8'h81, 1'b1, 166, 1'b0);
    repeat (10) @(posedge i_clk);

    // asynchronous reset during data bit 4
    align();
    send_partial(8'h99);
    #3;
    i_rst_n = 1'b0;
    held = 8'h00;
    #1;
    check("midrst_data", int'(o_rx_data), 0);
    check("midrst_busy", int'(o_rx_busy), 0);
    check("midrst_valid", int'(o_rx_valid), 0);
    check("midrst_ferr", int'(o_frame_err), 0);
    i_rx_serial = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (5) @(posedge i_clk);
    push_v(8'h7E);
    align();
    send_byte(8'h7E, 1'b1, TBIT, 1'b0);
    repeat (10) @(posedge i_clk);

    // enable dropped during data bit 4
    align();
    send_partial(8'h18);
    i_en = 1'b0;
    @(posedge i_clk);
    #1;
    check("en_low_busy", int'(o_rx_busy), 0);
    check("en_low_data_held", int'(o_rx_data), 'h7E);
    i_rx_serial = 1'b1;
    repeat (5) @(posedge i_clk);
    i_en = 1'b1;
    repeat (5) @(posedge i_clk);
    push_v(8'h7E);
    align();
    send_byte(8'h7E, 1'b1, TBIT, 1'b0);
    repeat (20) @(posedge i_clk);

    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
